// File: rtl/sum_sched_pkg.sv
// Shared types and helpers for the summing scheduler.
// Width math and size clamping live here so top and bench agree.
package sum_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_e;

  function automatic int f_sumw(
    input int w,
    input int nval
  );
    return w + $clog2(nval);
  endfunction

  // Negative counts mean "nothing to sum".
  function automatic int size_clamp(
    input int size,
    input int nval
  );
    if (size < 0) return 0;
    if (size > nval) return nval;
    return size;
  endfunction

endpackage

// File: rtl/sum_req_scheduler_if.sv
// Request/response bundle between requesters and the scheduler.
// master drives requests and consumes results; slave is the scheduler.
interface sum_req_scheduler_if
  import sum_sched_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int NVAL = 4,
  parameter int W    = 32
);

  localparam int SUMW = f_sumw(W, NVAL);
  localparam int IW   = $clog2(NREQ);

  logic [NREQ-1:0]                  req_valid;
  logic [NREQ-1:0]                  req_ready;
  logic [NREQ-1:0][NVAL-1:0][W-1:0] req_values;
  logic [NREQ-1:0][31:0]            req_size;
  logic                             resp_valid;
  logic                             resp_ready;
  logic [IW-1:0]                    resp_id;
  logic [SUMW-1:0]                  resp_sum;

  modport master (
    output req_valid, req_values, req_size,
    output resp_ready,
    input  req_ready,
    input  resp_valid, resp_id, resp_sum
  );

  modport slave (
    input  req_valid, req_values, req_size,
    input  resp_ready,
    output req_ready,
    output resp_valid, resp_id, resp_sum
  );

endinterface

// File: rtl/sum_serial_engine.sv
// Serial adder: captures a vector on load, then adds one element
// per cycle until size_eff elements are consumed.
module sum_serial_engine #(
  parameter int NVAL = 4,
  parameter int W    = 32,
  parameter int SUMW = 34,
  parameter int CW   = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic [NVAL-1:0][W-1:0]   vec,
  input  logic [CW-1:0]            size_eff,
  output logic                     busy,
  output logic                     last,
  output logic [SUMW-1:0]          sum
);

  localparam int IXW = (NVAL > 1) ? $clog2(NVAL) : 1;

  logic [NVAL-1:0][W-1:0] vec_q, vec_d;
  logic [CW-1:0]          size_q, size_d;
  logic [CW-1:0]          idx_q, idx_d;
  logic [SUMW-1:0]        acc_q, acc_d;
  logic                   busy_q, busy_d;

  assign busy = busy_q;
  assign last = busy_q && (idx_q == size_q - 1'b1);
  // Exposes the post-add value so the final sum is ready on the last step.
  assign sum  = acc_d;

  always_comb begin
    vec_d  = vec_q;
    size_d = size_q;
    idx_d  = idx_q;
    acc_d  = acc_q;
    busy_d = busy_q;
    if (load) begin
      vec_d  = vec;
      size_d = size_eff;
      idx_d  = '0;
      acc_d  = '0;
      busy_d = (size_eff != '0);
    end else if (busy_q) begin
      acc_d = acc_q + SUMW'(vec_q[idx_q[IXW-1:0]]);
      idx_d = idx_q + 1'b1;
      if (last) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vec_q  <= '0;
      size_q <= '0;
      idx_q  <= '0;
      acc_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      vec_q  <= vec_d;
      size_q <= size_d;
      idx_q  <= idx_d;
      acc_q  <= acc_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/sum_req_scheduler.sv
// Round-robin front end sharing one serial summing engine
// among NREQ requesters; one result in flight at a time.
module sum_req_scheduler
  import sum_sched_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int NVAL = 4,
  parameter int W    = 32,
  localparam int SUMW = f_sumw(W, NVAL)
) (
  input logic              clk,
  input logic              rst_n,
  sum_req_scheduler_if.slave bus
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(NVAL + 1);

  state_e          state_q, state_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [IW-1:0]   id_q, id_d;
  logic [SUMW-1:0] sum_q, sum_d;

  logic            gnt_vld;
  logic [IW-1:0]   gnt_idx;
  logic [CW-1:0]   size_eff;
  logic            load;
  logic            eng_busy;
  logic            eng_last;
  logic [SUMW-1:0] eng_sum;

  // Descending scan so the lowest offset from rr_q wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req_valid[(int'(rr_q) + k) % NREQ]) begin
        gnt_vld = 1'b1;
        gnt_idx = IW'((int'(rr_q) + k) % NREQ);
      end
    end
  end

  assign size_eff = CW'(size_clamp(
    int'($signed(bus.req_size[gnt_idx])), NVAL));

  sum_serial_engine #(
    .NVAL (NVAL),
    .W    (W),
    .SUMW (SUMW),
    .CW   (CW)
  ) u_eng (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .vec      (bus.req_values[gnt_idx]),
    .size_eff (size_eff),
    .busy     (eng_busy),
    .last     (eng_last),
    .sum      (eng_sum)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      id_q    <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      sum_q   <= sum_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_vld)
          state_d = (size_eff == '0) ? DONE : ACC;
      end
      ACC: begin
        if (eng_last || !eng_busy) state_d = DONE;
      end
      DONE: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rr_d  = rr_q;
    id_d  = id_q;
    sum_d = sum_q;
    if (state_q == IDLE && gnt_vld) begin
      id_d = gnt_idx;
      if (size_eff == '0) sum_d = '0;
    end
    if (state_q == ACC && eng_last) sum_d = eng_sum;
    if (state_q == DONE && bus.resp_ready)
      rr_d = (id_q == IW'(NREQ - 1)) ? '0 : id_q + 1'b1;
  end

  always_comb begin
    load          = 1'b0;
    bus.req_ready = '0;
    if (state_q == IDLE && gnt_vld) begin
      load                   = 1'b1;
      bus.req_ready[gnt_idx] = 1'b1;
    end
  end

  assign bus.resp_valid = (state_q == DONE);
  assign bus.resp_id    = id_q;
  assign bus.resp_sum   = sum_q;

endmodule

// File: tb/tb_sum_req_scheduler.sv
// Bench for sum_req_scheduler: directed corner cases, then
// random traffic checked against a transaction-level model.
module tb_sum_req_scheduler;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;
  int   rr_m;

  sum_req_scheduler_if #(
    .NREQ (2), .NVAL (4), .W (32)
  ) bus ();

  sum_req_scheduler #(
    .NREQ (2), .NVAL (4), .W (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int m_size(input int g);
    int s;
    s = int'($signed(bus.req_size[g]));
    if (s < 0) s = 0;
    if (s > 4) s = 4;
    return s;
  endfunction

  function automatic logic [33:0] m_sum(input int g);
    logic [33:0] s;
    s = '0;
    for (int i = 0; i < m_size(g); i++)
      s += 34'(bus.req_values[g][i]);
    return s;
  endfunction

  task automatic set_req(input int i, input int sz);
    bus.req_values[i] = {32'd4, 32'd3, 32'd2, 32'd1};
    bus.req_size[i]   = 32'(sz);
  endtask

  task automatic run_txn(
    input logic [1:0] mask,
    input int         hold
  );
    int g, se, n, lat;
    logic [33:0] es;
    g = -1;
    for (int k = 0; k < 2; k++)
      if (g < 0 && mask[(rr_m + k) % 2]) g = (rr_m + k) % 2;
    bus.req_valid  = mask;
    bus.resp_ready = 1'b0;
    @(negedge clk);
    n = 0;
    while (bus.req_ready == '0 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("gnt_wait", 64'(n), 64'd0);
    chk("gnt", 64'(bus.req_ready), 64'd1 << g);
    es = m_sum(g);
    se = m_size(g);
    @(posedge clk);
    #1;
    bus.req_valid[g]  = 1'b0;
    bus.req_values[g] = {$urandom, $urandom, $urandom, $urandom};
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      chk("rdy_busy", 64'(bus.req_ready), 64'd0);
    end while (!bus.resp_valid && lat < 20);
    chk("lat", 64'(lat), 64'(se + 1));
    chk("sum", 64'(bus.resp_sum), 64'(es));
    chk("id", 64'(bus.resp_id), 64'(g));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_vld", 64'(bus.resp_valid), 64'd1);
      chk("hold_sum", 64'(bus.resp_sum), 64'(es));
      chk("hold_id", 64'(bus.resp_id), 64'(g));
      chk("hold_rdy", 64'(bus.req_ready), 64'd0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    rr_m = (g + 1) % 2;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rr_m  = 0;
    rst_n = 1'b0;
    bus.req_valid  = '0;
    bus.req_values = '0;
    bus.req_size   = '0;
    bus.resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    bus.req_valid = 2'b00;
    @(negedge clk);
    chk("rst_rdy", 64'(bus.req_ready), 64'd0);
    chk("rst_vld", 64'(bus.resp_valid), 64'd0);
    chk("rst_sum", 64'(bus.resp_sum), 64'd0);
    chk("rst_id", 64'(bus.resp_id), 64'd0);
    @(posedge clk);
    #1;

    set_req(0, 4);  run_txn(2'b01, 0);
    set_req(0, 2);  run_txn(2'b01, 0);
    set_req(0, 7);  run_txn(2'b01, 0);
    set_req(0, 0);  run_txn(2'b01, 0);
    set_req(0, -5); run_txn(2'b01, 0);
    set_req(0, 4);  run_txn(2'b01, 3);

    bus.req_values[0] = '1;
    bus.req_size[0]   = 32'd4;
    run_txn(2'b01, 0);

    // rr_m is 1 here, so req1 wins; abort it mid-accumulation.
    set_req(1, 4);
    bus.req_valid = 2'b10;
    @(negedge clk);
    chk("abort_gnt", 64'(bus.req_ready), 64'd2);
    @(posedge clk);
    #1;
    bus.req_valid = 2'b00;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rr_m  = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_novld", 64'(bus.resp_valid), 64'd0);
    end
    @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++) begin
      set_req(0, 3);
      set_req(1, 4);
      run_txn(2'b11, 0);
    end

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 2; i++) begin
        for (int j = 0; j < 4; j++)
          bus.req_values[i][j] =
            ($urandom_range(0, 3) == 0) ? '1 : $urandom;
        bus.req_size[i] =
          32'(int'($urandom_range(0, 10)) - 3);
      end
      run_txn(2'($urandom_range(1, 3)),
              int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
